vga_prefetch_ctrl: RTL and testbench
====================================

// Module: vga_prefetch_ctrl
// PURPOSE
//  Prefetch sequencer between the SDRAM read port and the pixel fifo of the VGA path.
//  - Tracks fifo occupancy itself and issues fixed-length SDRAM burst reads whenever a whole burst fits.
//  - Pushes returned beats into the fifo and walks a linear frame address range.
//  - On each frame start: realigns to the frame base and flushes the fifo.
// PARAMETERS
//  ADDR_W       24      SDRAM word address width
//  DATA_W       16      pixel/data word width
//  BURST_LEN    8       words per burst read (power of 2, >=2)
//  FIFO_DEPTH   16      pixel fifo capacity in words (2**W of the attached fifo)
//  FRAME_WORDS  307200  words per frame (multiple of BURST_LEN)
//  BASE_ADDR    0       SDRAM word address of frame pixel 0
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst_n        in   1        synchronous active-low reset
//  enable       in   1        1 = allow new burst requests
//  frame_start  in   1        1-cycle pulse at start of vertical blanking
//  rd_req       out  1        burst read request to SDRAM controller
//  rd_addr      out  ADDR_W   burst start address, stable while rd_req=1
//  rd_ack       in   1        1-cycle accept of current request
//  rd_valid     in   1        one returned data beat
//  rd_data      in   DATA_W   returned data beat
//  fifo_wr      out  1        write strobe to pixel fifo
//  fifo_wr_data out  DATA_W   write data to pixel fifo
//  fifo_flush   out  1        1-cycle pulse; top level resets pixel fifo with it
//  fifo_rd      in   1        VGA-side read strobe (same signal driving the fifo)
//  level        out  $clog2(FIFO_DEPTH+1)  tracked fifo occupancy
//  busy         out  1        1 while a burst is requested or in flight
//  underrun     out  1        sticky: fifo_rd seen while level==0
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//  - State IDLE; all outputs 0.
//  - Internal offset=0, words_left=0: no requests until first frame_start.
//  States:
//  - IDLE->REQ when enable & words_left!=0 & level<=FIFO_DEPTH-BURST_LEN & !restart_pend.
//  - REQ: rd_req=1 with rd_addr=BASE_ADDR+offset. Held until rd_ack; never withdrawn. REQ->DATA on rd_ack.
//  - DATA: count rd_valid beats; after beat BURST_LEN go to IDLE.
//    - On exit: offset+=BURST_LEN, words_left-=BURST_LEN.
//    - If restart_pend, go to FLUSH instead.
//  - FLUSH (1 cycle):
//    - fifo_flush=1, level<=0, offset<=0, words_left<=FRAME_WORDS.
//    - underrun<=0, restart_pend<=0.
//    - Then IDLE.
//  frame_start:
//  - In IDLE: next state FLUSH.
//  - In REQ/DATA: set restart_pend. Current burst completes handshake; its remaining beats are
//    discarded (fifo_wr suppressed from the pulse cycle onward). Then FLUSH.
//  - A second pulse while pending is absorbed.
//  Push path:
//  - fifo_wr/fifo_wr_data are registered copies of rd_valid/rd_data (latency 1 clk).
//  - rd_valid outside DATA is ignored.
//  Level:
//  - +1 on fifo_wr.
//  - -1 on fifo_rd & level!=0.
//  - Both in the same cycle: unchanged.
//  - FLUSH overrides both.
//  - The admission rule guarantees level never exceeds FIFO_DEPTH.
//  underrun: set on fifo_rd & level==0; cleared only by FLUSH or reset.
//  busy = (state==REQ)|(state==DATA).
//  enable=0: blocks only IDLE->REQ; an in-flight burst finishes normally.
//  End of frame: words_left==0 -> stay IDLE until frame_start (no address wrap mid-frame).
//  Arithmetic: offset is ADDR_W bits, words_left is $clog2(FRAME_WORDS+1) bits, unsigned, no saturation needed.
//  Reset mid-burst: abandons burst immediately; late rd_valid beats are ignored (state IDLE).
// TESTING
//  1. Reset, frame_start, enable=1, no fifo_rd.
//     -> FLUSH pulse, then request at addr 0; ack; 8 beats
//     -> 8 fifo_wr one clk after each rd_valid; level=8.
//     -> Second request at addr 8; after 16 words no further rd_req.
//  2. Level=8, then fifo_rd and rd_valid beat in the same cycle -> level stays 8 on that cycle.
//     With level=9, no rd_req issues until fifo_rd brings level to 8.
//  3. frame_start during DATA after beat 3:
//     -> beats 4-8 produce no fifo_wr; one-cycle fifo_flush after beat 8; level=0.
//     -> Next rd_addr=BASE_ADDR.
//  4. frame_start while rd_req held without ack for 5 clks:
//     -> rd_req and rd_addr stay stable until ack.
//     -> All 8 beats discarded, then FLUSH.
//  5. FRAME_WORDS=32, run a full frame:
//     -> requests at 0,8,16,24 only; idle afterwards.
//     -> fifo_rd at level 0 sets underrun; the next frame_start clears it.
//  6. rst_n=0 during DATA, then 3 stray rd_valid beats -> no fifo_wr; all outputs 0; no rd_req until frame_start.

Source files
------------

// File: rtl/vga_prefetch_ctrl.sv
// Prefetch sequencer: issues SDRAM bursts when a whole burst fits in the pixel fifo and pushes the returned beats (1 clk latency).
// Requests are held until accepted. Beats are never backpressured, so room for a whole burst is reserved before the request is issued.
module vga_prefetch_ctrl #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 307200,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              frame_start,
    output logic                              rd_req,
    output logic [ADDR_W-1:0]                 rd_addr,
    input  logic                              rd_ack,
    input  logic                              rd_valid,
    input  logic [DATA_W-1:0]                 rd_data,
    output logic                              fifo_wr,
    output logic [DATA_W-1:0]                 fifo_wr_data,
    output logic                              fifo_flush,
    input  logic                              fifo_rd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              busy,
    output logic                              underrun
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int WL_W  = $clog2(FRAME_WORDS + 1);
    localparam int BC_W  = $clog2(BURST_LEN);
    localparam logic [LVL_W:0] ADMIT_MAX = (LVL_W+1)'(FIFO_DEPTH - BURST_LEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_offset;
    logic [WL_W-1:0]   r_words_left;
    logic [BC_W-1:0]   r_beat_cnt;
    logic              r_restart_pend;
    logic              r_fifo_wr;
    logic [DATA_W-1:0] r_fifo_wr_data;
    logic [LVL_W-1:0]  r_level;
    logic              r_underrun;

    logic              w_last_beat;
    logic              w_push;
    logic              w_dec;
    logic [LVL_W:0]    w_eff_level;
    logic              w_admit;

    assign w_last_beat = (r_state == S_DATA) && rd_valid && (r_beat_cnt == BC_W'(BURST_LEN - 1));
    assign w_push      = (r_state == S_DATA) && rd_valid && !r_restart_pend && !frame_start;
    assign w_dec       = fifo_rd && (r_level != '0);
    // The final beat's write is still in the output register when IDLE re-arbitrates; count it as occupied.
    assign w_eff_level = {1'b0, r_level} + {{LVL_W{1'b0}}, r_fifo_wr};
    assign w_admit     = enable && (r_words_left != '0) && (w_eff_level <= ADMIT_MAX) && !r_restart_pend;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_start)  w_state_nxt = S_FLUSH;
                else if (w_admit) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (rd_ack) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_last_beat) w_state_nxt = (r_restart_pend || frame_start) ? S_FLUSH : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_offset       <= '0;
            r_words_left   <= '0;
            r_beat_cnt     <= '0;
            r_restart_pend <= 1'b0;
            r_fifo_wr      <= 1'b0;
            r_fifo_wr_data <= '0;
            r_level        <= '0;
            r_underrun     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_fifo_wr <= w_push;
            if (w_push) r_fifo_wr_data <= rd_data;

            if (r_state == S_DATA && rd_valid) r_beat_cnt <= r_beat_cnt + BC_W'(1);
            else if (r_state != S_DATA)        r_beat_cnt <= '0;

            if (r_state == S_FLUSH) begin
                r_restart_pend <= 1'b0;
                r_offset       <= '0;
                r_words_left   <= WL_W'(FRAME_WORDS);
                r_level        <= '0;
                r_underrun     <= 1'b0;
            end else begin
                if (frame_start && (r_state == S_REQ || r_state == S_DATA)) r_restart_pend <= 1'b1;
                if (w_last_beat) begin
                    r_offset     <= r_offset + ADDR_W'(BURST_LEN);
                    r_words_left <= r_words_left - WL_W'(BURST_LEN);
                end
                case ({r_fifo_wr, w_dec})
                    2'b10:   r_level <= r_level + LVL_W'(1);
                    2'b01:   r_level <= r_level - LVL_W'(1);
                    default: r_level <= r_level;
                endcase
                if (fifo_rd && r_level == '0) r_underrun <= 1'b1;
            end
        end
    end

    assign rd_req       = (r_state == S_REQ);
    assign rd_addr      = rd_req ? (BASE_ADDR + r_offset) : '0;
    assign busy         = (r_state == S_REQ) || (r_state == S_DATA);
    assign fifo_flush   = (r_state == S_FLUSH);
    assign fifo_wr      = r_fifo_wr;
    assign fifo_wr_data = r_fifo_wr_data;
    assign level        = r_level;
    assign underrun     = r_underrun;
endmodule

// File: tb/tb_vga_prefetch_ctrl.sv
// Directed bench for vga_prefetch_ctrl with a 32-word frame at a non-zero base address.
module tb_vga_prefetch_ctrl;
    localparam logic [23:0] BASE = 24'h000100;

    logic        clk = 1'b0;
    logic        rst_n, enable, frame_start, rd_ack, rd_valid, fifo_rd;
    logic [15:0] rd_data;
    logic        rd_req, fifo_wr, fifo_flush, busy, underrun;
    logic [23:0] rd_addr;
    logic [15:0] fifo_wr_data;
    logic [4:0]  level;

    int tests_run = 0;
    int tests_failed = 0;

    vga_prefetch_ctrl #(
        .ADDR_W(24), .DATA_W(16), .BURST_LEN(8), .FIFO_DEPTH(16),
        .FRAME_WORDS(32), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
        .rd_data(rd_data), .fifo_wr(fifo_wr), .fifo_wr_data(fifo_wr_data),
        .fifo_flush(fifo_flush), .fifo_rd(fifo_rd), .level(level), .busy(busy),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; rd_ack = 1'b0;
        rd_valid = 1'b0; rd_data = '0; fifo_rd = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rd_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        int reqs;
        do_reset();
        tests_run++;
        if ({rd_req, busy, fifo_wr, fifo_flush, underrun} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got %b want 00000", {rd_req, busy, fifo_wr, fifo_flush, underrun});
        end
        tests_run++;
        if (level !== 5'd0 || rd_addr !== 24'd0 || fifo_wr_data !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_values got level=%0d addr=%0h data=%0h want 0", level, rd_addr, fifo_wr_data);
        end
        enable = 1'b1;
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rd_req) reqs++;
        end
        tests_run++;
        if (reqs !== 0) begin
            tests_failed++;
            $display("FAIL no_req_before_frame got %0d req cycles want 0", reqs);
        end
    endtask

    task automatic test_first_bursts;
        bit ok;
        int reqs;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tests_run++;
        if (fifo_flush !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_pulse got %b want 1", fifo_flush);
        end
        tick();
        tests_run++;
        if (fifo_flush !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_one_cycle got %b want 0", fifo_flush);
        end
        for (int b = 0; b < 2; b++) begin
            wait_req(10, ok);
            tests_run++;
            if (!ok || rd_addr !== BASE + 24'(8 * b) || (b == 1 && level !== 5'd8)) begin
                tests_failed++;
                $display("FAIL burst%0d_req got ok=%0d addr=%0h level=%0d want addr=%0h", b, ok, rd_addr, level, BASE + 24'(8 * b));
            end
            rd_ack = 1'b1;
            tick();
            rd_ack = 1'b0;
            for (int i = 0; i < 8; i++) begin
                rd_valid = 1'b1;
                rd_data = 16'hA000 + 16'(8 * b + i);
                tick();
                tests_run++;
                if (fifo_wr !== 1'b1 || fifo_wr_data !== 16'hA000 + 16'(8 * b + i)) begin
                    tests_failed++;
                    $display("FAIL push_b%0d_%0d got wr=%b data=%0h want 1/%0h", b, i, fifo_wr, fifo_wr_data, 16'hA000 + 16'(8 * b + i));
                end
            end
            rd_valid = 1'b0;
        end
        tick();
        tests_run++;
        if (level !== 5'd16) begin
            tests_failed++;
            $display("FAIL level_full got %0d want 16", level);
        end
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_req) reqs++;
        end
        tests_run++;
        if (reqs !== 0) begin
            tests_failed++;
            $display("FAIL no_req_when_full got %0d want 0", reqs);
        end
    endtask

    task automatic test_level;
        fifo_rd = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        tests_run++;
        if (rd_req !== 1'b0 || level !== 5'd9) begin
            tests_failed++;
            $display("FAIL level9_block got req=%b level=%0d want 0/9", rd_req, level);
        end
        tick();
        fifo_rd = 1'b0;
        tests_run++;
        if (rd_req !== 1'b0 || level !== 5'd8) begin
            tests_failed++;
            $display("FAIL level8 got req=%b level=%0d want 0/8", rd_req, level);
        end
        tick();
        tests_run++;
        if (rd_req !== 1'b1 || rd_addr !== BASE + 24'd16) begin
            tests_failed++;
            $display("FAIL req_at_8 got req=%b addr=%0h want 1/%0h", rd_req, rd_addr, BASE + 24'd16);
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        rd_valid = 1'b1;
        tick();
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        tests_run++;
        if (level !== 5'd8 || fifo_wr !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_wr_same_cycle got level=%0d wr=%b want 8/1", level, fifo_wr);
        end
        for (int i = 0; i < 6; i++) tick();
        rd_valid = 1'b0;
        tick();
        tests_run++;
        if (level !== 5'd15) begin
            tests_failed++;
            $display("FAIL level_after_burst got %0d want 15", level);
        end
    endtask

    task automatic test_restart_in_data;
        bit ok;
        int wrs;
        start_frame();
        wait_req(10, ok);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1'b1;
            tick();
        end
        rd_valid = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wrs = 0;
        for (int i = 0; i < 5; i++) begin
            rd_valid = 1'b1;
            tick();
            if (fifo_wr) wrs++;
        end
        rd_valid = 1'b0;
        tests_run++;
        if (wrs !== 0 || fifo_flush !== 1'b1) begin
            tests_failed++;
            $display("FAIL data_restart got wrs=%0d flush=%b want 0/1", wrs, fifo_flush);
        end
        tick();
        tests_run++;
        if (level !== 5'd0 || fifo_flush !== 1'b0) begin
            tests_failed++;
            $display("FAIL data_restart_level got level=%0d flush=%b want 0/0", level, fifo_flush);
        end
        wait_req(10, ok);
        tests_run++;
        if (!ok || rd_addr !== BASE) begin
            tests_failed++;
            $display("FAIL data_restart_addr got ok=%0d addr=%0h want %0h", ok, rd_addr, BASE);
        end
    endtask

    task automatic test_restart_in_req;
        bit ok;
        int bad;
        int wrs;
        wait_req(10, ok);
        bad = ok ? 0 : 1;
        for (int c = 0; c < 5; c++) begin
            frame_start = (c == 1 || c == 3);
            tick();
            if (rd_req !== 1'b1 || rd_addr !== BASE || busy !== 1'b1) bad++;
        end
        frame_start = 1'b0;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL req_held got %0d bad cycles want 0", bad);
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        wrs = 0;
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1;
            tick();
            if (fifo_wr) wrs++;
        end
        rd_valid = 1'b0;
        tests_run++;
        if (wrs !== 0 || fifo_flush !== 1'b1) begin
            tests_failed++;
            $display("FAIL req_restart got wrs=%0d flush=%b want 0/1", wrs, fifo_flush);
        end
        tick();
        tick();
        tests_run++;
        if (fifo_flush !== 1'b0 || rd_req !== 1'b1 || rd_addr !== BASE || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL req_restart_after got flush=%b req=%b addr=%0h level=%0d want 0/1/%0h/0", fifo_flush, rd_req, rd_addr, level, BASE);
        end
    endtask

    task automatic test_full_frame;
        bit ok;
        int reqs;
        do_reset();
        enable = 1'b1;
        start_frame();
        for (int k = 0; k < 4; k++) begin
            wait_req(20, ok);
            tests_run++;
            if (!ok || rd_addr !== BASE + 24'(8 * k)) begin
                tests_failed++;
                $display("FAIL frame_req%0d got ok=%0d addr=%0h want %0h", k, ok, rd_addr, BASE + 24'(8 * k));
            end
            rd_ack = 1'b1;
            tick();
            rd_ack = 1'b0;
            rd_valid = 1'b1;
            for (int i = 0; i < 8; i++) tick();
            rd_valid = 1'b0;
            tick();
            tests_run++;
            if (level !== 5'd8) begin
                tests_failed++;
                $display("FAIL frame_level%0d got %0d want 8", k, level);
            end
            fifo_rd = 1'b1;
            for (int i = 0; i < 8; i++) tick();
            fifo_rd = 1'b0;
        end
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_req) reqs++;
        end
        tests_run++;
        if (reqs !== 0 || underrun !== 1'b0 || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL frame_end got reqs=%0d underrun=%b level=%0d want 0/0/0", reqs, underrun, level);
        end
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        tests_run++;
        if (underrun !== 1'b1 || level !== 5'd0) begin
            tests_failed++;
            $display("FAIL underrun_set got underrun=%b level=%0d want 1/0", underrun, level);
        end
        start_frame();
        tests_run++;
        if (underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL underrun_clear got %b want 0", underrun);
        end
        wait_req(10, ok);
        tests_run++;
        if (!ok || rd_addr !== BASE) begin
            tests_failed++;
            $display("FAIL frame2_req got ok=%0d addr=%0h want %0h", ok, rd_addr, BASE);
        end
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        int wrs;
        int reqs;
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        rd_valid = 1'b1;
        rd_data = 16'h5A5A;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++;
        if ({rd_req, busy, fifo_wr, fifo_flush, underrun} !== 5'b0 || level !== 5'd0 || rd_addr !== 24'd0) begin
            tests_failed++;
            $display("FAIL midreset got flags=%b level=%0d addr=%0h want 0", {rd_req, busy, fifo_wr, fifo_flush, underrun}, level, rd_addr);
        end
        wrs = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (fifo_wr || fifo_wr_data !== 16'd0 || busy) wrs++;
        end
        rd_valid = 1'b0;
        tests_run++;
        if (wrs !== 0) begin
            tests_failed++;
            $display("FAIL stray_beats got %0d bad cycles want 0", wrs);
        end
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_req) reqs++;
        end
        enable = 1'b0;
        start_frame();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_req) reqs++;
        end
        tests_run++;
        if (reqs !== 0) begin
            tests_failed++;
            $display("FAIL idle_after_reset_or_disabled got %0d req cycles want 0", reqs);
        end
        enable = 1'b1;
        wait_req(10, ok);
        tests_run++;
        if (!ok || rd_addr !== BASE) begin
            tests_failed++;
            $display("FAIL enable_req got ok=%0d addr=%0h want %0h", ok, rd_addr, BASE);
        end
    endtask

    initial begin
        test_reset();
        test_first_bursts();
        test_level();
        test_restart_in_data();
        test_restart_in_req();
        test_full_frame();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
